// File: rtl/id_ex_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register slice.
// Holds the decoded-control struct, the ALU opcode encodings and the default datapath width.
package id_ex_reg_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int REG_IDX_W          = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_BGE = 4'b1001;
    localparam logic [3:0] ALU_BNE = 4'b1010;
    localparam logic [3:0] ALU_SLT = 4'b1100;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
    } id_ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select for one source register.
// EX/MEM has priority over MEM/WB; register index 0 is never bypassed.
module fwd_mux
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [REG_IDX_W-1:0]  rs_idx_i,
    input  logic [DATA_WIDTH-1:0] rs_data_i,
    input  logic [REG_IDX_W-1:0]  exm_rd_i,
    input  logic                  exm_reg_write_i,
    input  logic [DATA_WIDTH-1:0] exm_result_i,
    input  logic [REG_IDX_W-1:0]  wb_rd_i,
    input  logic                  wb_reg_write_i,
    input  logic [DATA_WIDTH-1:0] wb_result_i,
    output logic [DATA_WIDTH-1:0] fwd_data_o
);

    logic exm_hit;
    logic wb_hit;

    assign exm_hit = exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == rs_idx_i);
    assign wb_hit  = wb_reg_write_i  && (wb_rd_i  != '0) && (wb_rd_i  == rs_idx_i);

    always_comb begin
        fwd_data_o = rs_data_i;
        if (exm_hit) begin
            fwd_data_o = exm_result_i;
        end else if (wb_hit) begin
            fwd_data_o = wb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall/load-use bubble control and
// EX-stage operand forwarding feeding the ALU inputs.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  id_ctrl_t              id_ctrl,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [REG_IDX_W-1:0]  id_rs1,
    input  logic [REG_IDX_W-1:0]  id_rs2,
    input  logic [REG_IDX_W-1:0]  id_rd,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [REG_IDX_W-1:0]  exm_rd,
    input  logic                  exm_reg_write,
    input  logic [DATA_WIDTH-1:0] exm_result,
    input  logic [REG_IDX_W-1:0]  wb_rd,
    input  logic                  wb_reg_write,
    input  logic [DATA_WIDTH-1:0] wb_result,
    output logic [DATA_WIDTH-1:0] SrcA,
    output logic [DATA_WIDTH-1:0] SrcB,
    output logic [3:0]            Operation,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic                  ex_valid,
    output id_ctrl_t              ex_ctrl,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [REG_IDX_W-1:0]  ex_rd,
    output logic                  hazard_stall
);

    logic                  valid_q,    valid_d;
    id_ctrl_t              ctrl_q,     ctrl_d;
    logic [DATA_WIDTH-1:0] pc_q,       pc_d;
    logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic [DATA_WIDTH-1:0] imm_q,      imm_d;
    logic [REG_IDX_W-1:0]  rs1_q,      rs1_d;
    logic [REG_IDX_W-1:0]  rs2_q,      rs2_d;
    logic [REG_IDX_W-1:0]  rd_q,       rd_d;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // Load-use: the held load's result is not available until MEM, so decode must wait.
    assign hazard_stall = valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                          ((rd_q == id_rs1) || (rd_q == id_rs2)) && id_valid;

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (hazard_stall) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d    = id_valid;
            ctrl_d     = id_valid ? id_ctrl : '0;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs1 (
        .rs_idx_i        (rs1_q),
        .rs_data_i       (rs1_data_q),
        .exm_rd_i        (exm_rd),
        .exm_reg_write_i (exm_reg_write),
        .exm_result_i    (exm_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .fwd_data_o      (SrcA)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_rs2 (
        .rs_idx_i        (rs2_q),
        .rs_data_i       (rs2_data_q),
        .exm_rd_i        (exm_rd),
        .exm_reg_write_i (exm_reg_write),
        .exm_result_i    (exm_result),
        .wb_rd_i         (wb_rd),
        .wb_reg_write_i  (wb_reg_write),
        .wb_result_i     (wb_result),
        .fwd_data_o      (fwd_rs2)
    );

    assign ex_store_data = fwd_rs2;
    assign SrcB          = ctrl_q.alu_src ? imm_q : fwd_rs2;
    assign Operation     = ctrl_q.alu_op;
    assign ex_valid      = valid_q;
    assign ex_ctrl       = ctrl_q;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 DATA_WIDTH, 32, width of operands, immediates, PC and forwarded results; register indices fixed at 5 bits.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 id_valid  in  1  decode stage presents a real instruction.
REQ-005 id_ctrl  in  id_ctrl_t  decoded control {alu_op[3:0], alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}.
REQ-006 id_pc  in  DATA_WIDTH  instruction PC.
REQ-007 id_rs1_data  in  DATA_WIDTH  register-file read port 1.
REQ-008 id_rs2_data  in  DATA_WIDTH  register-file read port 2.
REQ-009 id_imm  in  DATA_WIDTH  sign-extended immediate.
REQ-010 id_rs1  in  5  source index 1.
REQ-011 id_rs2  in  5  source index 2.
REQ-012 id_rd  in  5  destination index.
REQ-013 stall  in  1  downstream hold; freeze all registers.
REQ-014 flush  in  1  taken branch/jump; kill held instruction.
REQ-015 exm_rd, exm_reg_write, exm_result  in  5/1/DATA_WIDTH  EX/MEM writeback candidate.
REQ-016 wb_rd, wb_reg_write, wb_result  in  5/1/DATA_WIDTH  MEM/WB writeback candidate.
REQ-017 SrcA  out  DATA_WIDTH  forwarded ALU operand A.
REQ-018 SrcB  out  DATA_WIDTH  ALU operand B (immediate or forwarded rs2).
REQ-019 Operation  out  4  ALU opcode (ex_ctrl.alu_op).
REQ-020 ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores.
REQ-021 ex_valid, ex_ctrl, ex_pc, ex_rd  out  1/id_ctrl_t/DATA_WIDTH/5  registered instruction state.
REQ-022 hazard_stall  out  1  load-use hazard; decode and fetch must hold.

Function
REQ-023 Register update priority per edge: flush > stall > hazard_stall > normal load.
REQ-024 flush=1: ex_valid<=0, ex_ctrl<=0 (bubble) regardless of stall or hazard.
REQ-025 stall=1 (no flush): every register holds; SrcA/SrcB re-evaluate combinationally from held values and live forwarding inputs.
REQ-026 hazard_stall = ex_valid & ex_ctrl.mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) & id_valid; purely combinational.
REQ-027 hazard_stall=1 (no flush/stall): load bubble (ex_valid<=0, ex_ctrl<=0), decoded instruction not captured.
REQ-028 Normal load: all id_* captured with one-cycle latency; id_valid=0 captures a bubble (ctrl zeroed).
REQ-029 Forward A: exm_reg_write & exm_rd!=0 & exm_rd==rs1_q -> exm_result; else wb_reg_write & wb_rd!=0 & wb_rd==rs1_q -> wb_result; else rs1_data_q.
REQ-030 Forward rs2 identically using rs2_q; result drives ex_store_data.
REQ-031 SrcB = ex_ctrl.alu_src ? imm_q : forwarded rs2; Operation = ex_ctrl.alu_op unchanged.
REQ-032 EX/MEM wins when both stages match the same index; index 0 never forwards.
REQ-033 Bubbles yield Operation 4'b0000 (AND), all enables 0; no architectural effect.

Reset
REQ-034 reset asserted: ex_valid, ex_ctrl, ex_pc, ex_rd, and all captured data/index registers clear to 0 immediately, independent of clk.
REQ-035 Reset mid-stall or mid-hazard discards the held instruction; first post-reset edge performs a normal load.

Structure
REQ-036 Package holds id_ctrl_t, ALU opcode constants (AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, EQ 1000, BGE 1001, BNE 1010, SLT 1100) and DATA_WIDTH default.
REQ-037 One sub-module, fwd_mux, instantiated twice (rs1, rs2) implementing REQ-029/032.

Verification
REQ-038 Load ADD, rs1=5 data 10, rs2=6 data 3 -> next cycle SrcA=10, SrcB=3, Operation=0010.
REQ-039 rs1_q=5 with exm_rd=5 result 0xAA and wb_rd=5 result 0xBB, both writing -> SrcA=0xAA; drop exm_reg_write -> 0xBB.
REQ-040 Held LW rd=7, incoming id_rs2=7 -> hazard_stall=1, next cycle ex_valid=0; rd=0 variant -> hazard_stall=0.
REQ-041 flush and stall both high -> ex_valid=0, ex_ctrl=0 next cycle; stall alone 3 cycles -> outputs unchanged.
REQ-042 Assert reset between edges while ex_valid=1 -> ex_valid=0 before next edge; forward to rd=0 with 0xFF -> SrcA keeps register value.
